// File: rtl/perceptron_pkg.sv
// Shared FSM encoding and popcount helper for the perceptron matcher.
package perceptron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned POP_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/agree_count.sv
// Combinational agreement score: number of equal bit positions between a and b.
module agree_count
  import perceptron_pkg::*;
#(
  parameter  int N_BITS  = 16,
  localparam int SCORE_W = $clog2(N_BITS + 1)
) (
  input  logic [N_BITS-1:0]  a,
  input  logic [N_BITS-1:0]  b,
  output logic [SCORE_W-1:0] score
);

  logic [POP_MAX_W-1:0] agree;

  always_comb begin
    agree               = '0;
    agree[N_BITS-1:0]   = ~(a ^ b);
    score               = SCORE_W'(popcount(agree));
  end

endmodule

// File: rtl/perceptron_matcher.sv
// Sequential multi-class pattern matcher: scans one stored class per cycle and
// reports the best agreement score with valid/ready handshakes on both sides.
module perceptron_matcher
  import perceptron_pkg::*;
#(
  parameter  int N_BITS    = 16,
  parameter  int N_CLASSES = 4,
  localparam int SCORE_W   = $clog2(N_BITS + 1),
  localparam int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [N_BITS-1:0]  wr_weight,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_BITS-1:0]  in_pattern,
  input  logic [SCORE_W-1:0] in_threshold,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_recognition,
  output logic               out_exact
);

  state_t state, state_n;

  logic [N_BITS-1:0]  weights [N_CLASSES];
  logic [N_CLASSES-1:0] enabled;

  logic [IDX_W-1:0]   k;
  logic [N_BITS-1:0]  pat_q;
  logic [SCORE_W-1:0] thr_q;
  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   best_idx;
  logic               found;

  logic [SCORE_W-1:0] score_k;
  logic               take_k;
  logic               last_k;
  logic               wr_ok;
  logic [SCORE_W-1:0] nb_score;
  logic [IDX_W-1:0]   nb_idx;
  logic               nb_found;

  agree_count #(.N_BITS(N_BITS)) u_agree (
    .a     (pat_q),
    .b     (weights[k]),
    .score (score_k)
  );

  always_comb begin
    wr_ok    = wr_en && (state == IDLE) && (32'(wr_idx) < N_CLASSES);
    last_k   = (k == IDX_W'(N_CLASSES - 1));
    take_k   = enabled[k] && (!found || (score_k > best_score));
    nb_score = take_k ? score_k : best_score;
    nb_idx   = take_k ? k       : best_idx;
    nb_found = found || take_k;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = SCAN;
      SCAN:    if (last_k)    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  // A write coinciding with accept lands on the accept edge; the scan reads
  // weights from the following cycle onward, so the new weight participates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CLASSES; i++) begin
        weights[i] <= '0;
      end
      enabled         <= '0;
      k               <= '0;
      pat_q           <= '0;
      thr_q           <= '0;
      best_score      <= '0;
      best_idx        <= '0;
      found           <= 1'b0;
      out_idx         <= '0;
      out_score       <= '0;
      out_recognition <= 1'b0;
      out_exact       <= 1'b0;
    end else begin
      if (wr_ok) begin
        weights[wr_idx] <= wr_weight;
        enabled[wr_idx] <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            pat_q      <= in_pattern;
            thr_q      <= in_threshold;
            best_score <= '0;
            best_idx   <= '0;
            found      <= 1'b0;
            k          <= '0;
          end
        end
        SCAN: begin
          best_score <= nb_score;
          best_idx   <= nb_idx;
          found      <= nb_found;
          if (last_k) begin
            out_idx         <= nb_idx;
            out_score       <= nb_score;
            out_recognition <= nb_found && (nb_score >= thr_q);
            out_exact       <= (nb_score == SCORE_W'(N_BITS));
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_matcher.sv
// Directed, table-driven bench for perceptron_matcher (N_BITS=16, N_CLASSES=4).
module tb_perceptron_matcher;
  import perceptron_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [15:0] wr_weight;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pattern;
  logic [4:0]  in_threshold;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic [4:0]  out_score;
  logic        out_recognition;
  logic        out_exact;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  perceptron_matcher #(
    .N_BITS    (16),
    .N_CLASSES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_idx          (wr_idx),
    .wr_weight       (wr_weight),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pattern      (in_pattern),
    .in_threshold    (in_threshold),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_idx         (out_idx),
    .out_score       (out_score),
    .out_recognition (out_recognition),
    .out_exact       (out_exact)
  );

  typedef struct {
    bit          do_rst;
    bit          do_wr;
    logic [1:0]  widx;
    logic [15:0] wval;
    logic [15:0] pat;
    logic [4:0]  thr;
    logic [1:0]  eidx;
    logic [4:0]  escore;
    bit          erec;
    bit          eexact;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write_w(input logic [1:0] idx, input logic [15:0] w);
    wr_en     = 1'b1;
    wr_idx    = idx;
    wr_weight = w;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic start_req(input logic [15:0] p, input logic [4:0] t,
                           input bit cw, input logic [1:0] ci, input logic [15:0] cv);
    in_pattern   = p;
    in_threshold = t;
    in_valid     = 1'b1;
    wr_en        = cw;
    wr_idx       = ci;
    wr_weight    = cv;
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wr_en    = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic [15:0] p, input logic [4:0] t,
                         input bit cw, input logic [1:0] ci, input logic [15:0] cv,
                         input logic [1:0] eidx, input logic [4:0] es, input bit er, input bit ee);
    int lat;
    start_req(p, t, cw, ci, cv);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_idx"},     32'(out_idx), 32'(eidx));
    check({tag, "_score"},   32'(out_score), 32'(es));
    check({tag, "_recog"},   32'(out_recognition), 32'(er));
    check({tag, "_exact"},   32'(out_exact), 32'(ee));
    finish_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_weight = '0;
    in_valid = 1'b0; in_pattern = '0; in_threshold = '0; out_ready = 1'b0;

    //           rst wr idx  wval      pat       thr  eidx score rec exact
    vecs[0]  = '{1, 0, 2'd0, 16'h0000, 16'h1234, 5'd0,  2'd0, 5'd0,  0, 0};
    vecs[1]  = '{0, 1, 2'd0, 16'hE444, 16'hE444, 5'd16, 2'd0, 5'd16, 1, 1};
    vecs[2]  = '{0, 0, 2'd0, 16'h0000, 16'h4444, 5'd16, 2'd0, 5'd14, 0, 0};
    vecs[3]  = '{0, 0, 2'd0, 16'h0000, 16'hC444, 5'd15, 2'd0, 5'd15, 1, 0};
    vecs[4]  = '{0, 0, 2'd0, 16'h0000, 16'h4444, 5'd15, 2'd0, 5'd14, 0, 0};
    vecs[5]  = '{0, 0, 2'd0, 16'h0000, 16'h4444, 5'd0,  2'd0, 5'd14, 1, 0};
    vecs[6]  = '{0, 0, 2'd0, 16'h0000, 16'hE444, 5'd17, 2'd0, 5'd16, 0, 1};
    vecs[7]  = '{0, 0, 2'd0, 16'h0000, 16'h0000, 5'd10, 2'd0, 5'd10, 1, 0};
    vecs[8]  = '{0, 1, 2'd1, 16'hFFFF, 16'hFFFF, 5'd16, 2'd1, 5'd16, 1, 1};
    vecs[9]  = '{0, 0, 2'd0, 16'h0000, 16'h0000, 5'd10, 2'd0, 5'd10, 1, 0};
    vecs[10] = '{0, 0, 2'd0, 16'h0000, 16'hE444, 5'd16, 2'd0, 5'd16, 1, 1};
    vecs[11] = '{1, 1, 2'd1, 16'h00FF, 16'h00FF, 5'd16, 2'd1, 5'd16, 1, 1};
    vecs[12] = '{0, 1, 2'd2, 16'h00FF, 16'h00FF, 5'd16, 2'd1, 5'd16, 1, 1};
    vecs[13] = '{0, 0, 2'd0, 16'h0000, 16'hFF00, 5'd0,  2'd1, 5'd0,  1, 0};
    vecs[14] = '{0, 0, 2'd0, 16'h0000, 16'hFF00, 5'd1,  2'd1, 5'd0,  0, 0};
    vecs[15] = '{0, 1, 2'd3, 16'h0FF0, 16'hFF00, 5'd1,  2'd3, 5'd8,  1, 0};

    do_reset();
    check("reset_in_ready",  32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_idx",   32'(out_idx), 32'd0);
    check("reset_out_score", 32'(out_score), 32'd0);
    check("reset_out_recog", 32'(out_recognition), 32'd0);
    check("reset_out_exact", 32'(out_exact), 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_rst) do_reset();
      if (vecs[i].do_wr) write_w(vecs[i].widx, vecs[i].wval);
      run_req($sformatf("vec%0d", i), vecs[i].pat, vecs[i].thr, 1'b0, 2'd0, 16'h0000,
              vecs[i].eidx, vecs[i].escore, vecs[i].erec, vecs[i].eexact);
    end

    // Write coinciding with accept participates in that scan.
    do_reset();
    run_req("coincident_wr", 16'hABCD, 5'd16, 1'b1, 2'd3, 16'hABCD, 2'd3, 5'd16, 1, 1);

    // Back-pressure with ignored writes during SCAN and DONE.
    do_reset();
    write_w(2'd0, 16'hE444);
    start_req(16'hE444, 5'd16, 1'b0, 2'd0, 16'h0000);
    check("scan_in_ready_low", 32'(in_ready), 32'd0);
    write_w(2'd0, 16'hFFFF);
    wait_out(lat);
    check("hold_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) wr_en = 1'b1;
      wr_idx    = 2'd1;
      wr_weight = 16'hFFFF;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      check($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("hold%0d_idx", c),   32'(out_idx), 32'd0);
      check($sformatf("hold%0d_score", c), 32'(out_score), 32'd16);
      check($sformatf("hold%0d_recog", c), 32'(out_recognition), 32'd1);
      check($sformatf("hold%0d_exact", c), 32'(out_exact), 32'd1);
    end
    finish_out();
    check("post_handshake_ready", 32'(in_ready), 32'd1);
    check("post_handshake_valid", 32'(out_valid), 32'd0);
    run_req("ignored_wr", 16'hFFFF, 5'd0, 1'b0, 2'd0, 16'h0000, 2'd0,
            5'(popcount({48'h0, ~(16'hFFFF ^ 16'hE444)})), 1, 0);

    // Reset in the middle of a scan drops the result and clears the weights.
    write_w(2'd0, 16'hE444);
    start_req(16'hE444, 5'd16, 1'b0, 2'd0, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midscan_rst_valid", 32'(out_valid), 32'd0);
    check("midscan_rst_ready", 32'(in_ready), 32'd1);
    check("midscan_rst_score", 32'(out_score), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("midscan_rst_no_late_valid", 32'(out_valid), 32'd0);
    run_req("after_rst", 16'hE444, 5'd0, 1'b0, 2'd0, 16'h0000, 2'd0, 5'd0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
